seg_scan_display: RTL and testbench

//  Parametrised multiplexed seven-segment driver replacing the fixed 8-digit scanner fed by an external divided clock.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_tick_gen.sv | 24 ++
 rtl/seg_scan_display.sv | 125 ++++++++++++
 tb/tb_seg_scan_display.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Seven-segment display package: segment type, blank pattern and hex decoder.
package seg_pkg;

  // Cathode byte {dp,g,f,e,d,c,b,a}, active-low
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Hex nibble to active-low segment pattern, dp bit left off
  function automatic seg_t hex2seg(input logic [3:0] h);
    seg_t s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Prescaler: one-cycle tick every DIV system clocks (DIV >= 2).
module seg_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  // Free-running count 0..DIV-1, tick marks the last count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// per-digit decimal points and leading-zero blanking.
// Optional macro SEG_DISPLAY_DIM_EN adds a 4-bit brightness PWM on the anodes.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   datas,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
`ifdef SEG_DISPLAY_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output seg_t                  display_data,
  output logic [DIGITS-1:0]     display_en,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic                tick;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, act_data_q;
  logic [DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic                pend_vld_q;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          cur_nib;
  seg_t                seg_d, seg_q;
  logic [DIGITS-1:0]   en_d, en_q;

  seg_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  // Boundary is the tick on the last digit; buffers swap on the same edge
  // the index returns to 0, so the new frame starts with fresh data.
  assign frame_done = tick && (idx_q == IDX_LAST);
  assign idx_d      = frame_done ? '0 : idx_q + IW'(1);

  // Digit index advances once per scan slot
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       idx_q <= '0;
    else if (tick) idx_q <= idx_d;
  end

  // Pending/active double buffer; a load in the boundary cycle still lets
  // the old pending copy through and stays pending for the next frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
    end else begin
      if (frame_done && pend_vld_q) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
      end
      if (load) begin
        pend_data_q <= datas;
        pend_dp_q   <= dp;
        pend_vld_q  <= 1'b1;
      end else if (frame_done) begin
        pend_vld_q  <= 1'b0;
      end
    end
  end

  // lz[k]: nibbles DIGITS-1..k of the active value are all zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (act_data_q[4*DIGITS-1 -: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--)
      lz[k] = lz[k+1] && (act_data_q[4*k +: 4] == 4'h0);
  end

  assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_DISPLAY_DIM_EN
  logic [3:0] pwm_q;

  // Free-running PWM phase for anode dimming
  always_ff @(posedge clk or posedge clr) begin
    if (clr) pwm_q <= '0;
    else     pwm_q <= pwm_q + 4'd1;
  end
`endif

  // Next cathode/anode pattern for the current digit
  always_comb begin
    seg_d = hex2seg(cur_nib);
    if (blank_lz && (idx_q != '0) && lz[idx_q])
      seg_d[6:0] = 7'h7F;
    seg_d[7] = ~act_dp_q[idx_q];
    en_d = ~(DIGITS'(1) << idx_q);
`ifdef SEG_DISPLAY_DIM_EN
    if (pwm_q > brightness)
      en_d = '1;
`endif
  end

  // Registered pin drivers; dark while in reset
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q <= SEG_OFF;
      en_q  <= '1;
    end else begin
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign display_data = seg_q;
  assign display_en   = en_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (DIGITS=4, SCAN_DIV=4).
module tb_seg_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] datas = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
`ifdef SEG_DISPLAY_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif
  logic [7:0]  display_data;
  logic [3:0]  display_en;
  logic        frame_done;

  seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .clr          (clr),
    .datas        (datas),
    .dp           (dp),
    .load         (load),
    .blank_lz     (blank_lz),
`ifdef SEG_DISPLAY_DIM_EN
    .brightness   (brightness),
`endif
    .display_data (display_data),
    .display_en   (display_en),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] seg;   // seg[d] expected on digit d
    string           tag;
  } frame_t;

  frame_t     sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] en_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where frame_done is high, bounded
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    if (!frame_done) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done timeout: got none expected pulse within 64 clks");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    datas = d;
    dp    = p;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic push(input string tag, input logic [3:0][7:0] seg);
    frame_t f;
    f.tag = tag;
    f.seg = seg;
    sb.push_back(f);
  endtask

  // Monitor: on a frame boundary, check the following frame against the oldest expectation
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!clr && frame_done && sb.size() > 0) begin
        f = sb.pop_front();
        for (int d = 0; d < 4; d++) begin
          repeat ((d == 0) ? 2 : 4) @(negedge clk);
          chk($sformatf("%s d%0d anode", f.tag, d), 32'(display_en), 32'(en_tab[d]));
          chk($sformatf("%s d%0d seg", f.tag, d), 32'(display_data), 32'(f.seg[d]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1);
  end

  initial begin
    int n;
    // 1: reset state and scan rotation
    cyc(2);
    chk("reset anodes", 32'(display_en), 32'hF);
    chk("reset segs", 32'(display_data), 32'hFF);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    clr = 1'b0;
    @(negedge clk);
    chk("first anode d0", 32'(display_en), 32'hE);
    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    chk("frame period", 32'(n), 32'd16);
    cyc(3);
    push("t1 zeros", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // 2: mid-frame load is held until the boundary
    wait_fd();
    cyc(5);
    do_load(16'h12AF, 4'b0100);
    push("t2 12AF", {8'hF9, 8'h24, 8'h88, 8'h8E});

    // 3: last load wins; load in boundary cycle lands one frame later
    wait_fd();
    cyc(2);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    push("t3 2222", {8'hA4, 8'hA4, 8'hA4, 8'hA4});
    wait_fd();
    do_load(16'h3333, 4'b0000);
    push("t3 3333", {8'hB0, 8'hB0, 8'hB0, 8'hB0});

    // 4: leading-zero blanking
    wait_fd();
    cyc(3);
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    push("t4 0050", {8'hFF, 8'hFF, 8'h92, 8'hC0});
    wait_fd();
    cyc(3);
    do_load(16'h0000, 4'b0000);
    push("t4 0000", {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    wait_fd();
    cyc(3);
    do_load(16'h0000, 4'b1000);
    push("t4 dp3", {8'h7F, 8'hFF, 8'hFF, 8'hC0});
    wait_fd();
    cyc(16);

    // 5: reset mid-slot on digit 2 with a load pending
    blank_lz = 1'b0;
    cyc(10);
    chk("t5 on digit 2", 32'(display_en), 32'hB);
    do_load(16'h4444, 4'b0000);
    clr = 1'b1;
    #1;
    chk("t5 clr anodes", 32'(display_en), 32'hF);
    chk("t5 clr segs", 32'(display_data), 32'hFF);
    cyc(2);
    clr = 1'b0;
    @(negedge clk);
    chk("t5 restart d0", 32'(display_en), 32'hE);
    cyc(3);
    push("t5 cleared", {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    wait_fd();
    cyc(16);

`ifdef SEG_DISPLAY_DIM_EN
    // 6: anode PWM duty
    brightness = 4'd3;
    cyc(2);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (display_en != 4'hF) n++;
    end
    chk("t6 duty b=3", 32'(n), 32'd4);
    brightness = 4'd15;
    cyc(2);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (display_en != 4'hF) n++;
    end
    chk("t6 duty b=15", 32'(n), 32'd16);
`endif

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
